// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one RAM port between instruction fetch and data access
// Optional fetch starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic [31:0] iload,
    output logic        ihit,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic [31:0] dload,
    output logic        dhit,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic        ramready,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_IACC,
        S_DACC,
        S_IRESP,
        S_DRESP
    } state_t;

    localparam logic [9:0] WAIT_LAST = 10'(TIMEOUT - 1);

    state_t      state_q;
    logic        ram_ren_q;
    logic        ram_wen_q;
    logic [31:0] ram_addr_q;
    logic [31:0] ram_store_q;
    logic [31:0] resp_q;
    logic        ihit_q;
    logic        dhit_q;
    logic        err_q;
    logic [9:0]  wait_q;
    logic        d_req;
    logic        starve_trip;
    logic        grant_d;

    assign d_req = dREN | dWEN;

`ifdef ARB_STARVE_GUARD_EN
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    logic [3:0] starve_q;

    // Once data has won STARVE_LIMIT times over a waiting fetch, the fetch gets one turn.
    assign starve_trip = iREN && (starve_q == STARVE_MAX);

    always_ff @(posedge CLK) begin
        if (RST) begin
            starve_q <= 4'd0;
        end else if (state_q == S_IDLE) begin
            starve_q <= (iREN && grant_d) ? starve_q + 4'd1 : 4'd0;
        end
    end
`else
    assign starve_trip = 1'b0;
`endif

    assign grant_d = d_req && !starve_trip;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            ram_ren_q   <= 1'b0;
            ram_wen_q   <= 1'b0;
            ram_addr_q  <= 32'd0;
            ram_store_q <= 32'd0;
            resp_q      <= 32'd0;
            ihit_q      <= 1'b0;
            dhit_q      <= 1'b0;
            err_q       <= 1'b0;
            wait_q      <= 10'd0;
        end else begin
            ihit_q <= 1'b0;
            dhit_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    wait_q <= 10'd0;
                    if (grant_d) begin
                        state_q     <= S_DACC;
                        ram_addr_q  <= daddr;
                        ram_wen_q   <= dWEN;
                        ram_ren_q   <= dREN & ~dWEN;
                        ram_store_q <= dstore;
                    end else if (iREN) begin
                        state_q     <= S_IACC;
                        ram_addr_q  <= iaddr;
                        ram_ren_q   <= 1'b1;
                        ram_wen_q   <= 1'b0;
                        ram_store_q <= 32'd0;
                    end
                end
                S_IACC, S_DACC: begin
                    if (ramready) begin
                        resp_q      <= ramload;
                        ihit_q      <= (state_q == S_IACC);
                        dhit_q      <= (state_q == S_DACC);
                        state_q     <= (state_q == S_IACC) ? S_IRESP : S_DRESP;
                        ram_ren_q   <= 1'b0;
                        ram_wen_q   <= 1'b0;
                        ram_addr_q  <= 32'd0;
                        ram_store_q <= 32'd0;
                    end else if (wait_q == WAIT_LAST) begin
                        // Abort without a hit; the requester is still holding its request and retries.
                        err_q       <= 1'b1;
                        state_q     <= S_IDLE;
                        ram_ren_q   <= 1'b0;
                        ram_wen_q   <= 1'b0;
                        ram_addr_q  <= 32'd0;
                        ram_store_q <= 32'd0;
                    end else begin
                        wait_q <= wait_q + 10'd1;
                    end
                end
                S_IRESP, S_DRESP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ramREN   = ram_ren_q;
    assign ramWEN   = ram_wen_q;
    assign ramaddr  = ram_addr_q;
    assign ramstore = ram_store_q;
    assign iload    = resp_q;
    assign dload    = resp_q;
    assign ihit     = ihit_q;
    assign dhit     = dhit_q;
    assign err      = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter
module tb_mem_arbiter;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        iREN = 1'b0;
    logic [31:0] iaddr = 32'd0;
    logic [31:0] iload;
    logic        ihit;
    logic        dREN = 1'b0;
    logic        dWEN = 1'b0;
    logic [31:0] daddr = 32'd0;
    logic [31:0] dstore = 32'd0;
    logic [31:0] dload;
    logic        dhit;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic        ramready = 1'b0;
    logic        err;

    logic        ld_fixed = 1'b0;
    logic [31:0] ld_val = 32'd0;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] iq[$];
    logic [31:0] dq[$];
    logic [31:0] gq[$];
    logic        prev_en = 1'b0;

    // RAM model: returns a value derived from the address unless a fixed word is forced.
    assign ramload = ld_fixed ? ld_val : (ramaddr ^ KEY);

    mem_arbiter #(
        .STARVE_LIMIT(2),
        .TIMEOUT     (8)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .iREN    (iREN),
        .iaddr   (iaddr),
        .iload   (iload),
        .ihit    (ihit),
        .dREN    (dREN),
        .dWEN    (dWEN),
        .daddr   (daddr),
        .dstore  (dstore),
        .dload   (dload),
        .dhit    (dhit),
        .ramREN  (ramREN),
        .ramWEN  (ramWEN),
        .ramaddr (ramaddr),
        .ramstore(ramstore),
        .ramload (ramload),
        .ramready(ramready),
        .err     (err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    always @(negedge CLK) begin
        if (RST) begin
            prev_en = 1'b0;
        end else begin
            if (ihit && dhit) chk("both_hits", 32'd1, 32'd0);
            if (ihit) begin
                if (iq.size() == 0) chk("unexp_ihit", 32'd1, 32'd0);
                else chk("sb_iload", iload, iq.pop_front());
            end
            if (dhit) begin
                if (dq.size() == 0) chk("unexp_dhit", 32'd1, 32'd0);
                else chk("sb_dload", dload, dq.pop_front());
            end
            if ((ramREN || ramWEN) && !prev_en) gq.push_back(ramaddr);
            prev_en = ramREN || ramWEN;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_order[6];
        int cnt;
        bit  done;

        tick();
        tick();
        RST = 1'b0;
        chk("rst_ramREN", 32'(ramREN), 32'd0);
        chk("rst_ramWEN", 32'(ramWEN), 32'd0);
        chk("rst_ramaddr", ramaddr, 32'd0);
        chk("rst_ramstore", ramstore, 32'd0);
        chk("rst_hits", {30'd0, ihit, dhit}, 32'd0);
        chk("rst_load", iload | dload, 32'd0);
        chk("rst_err", 32'(err), 32'd0);

        // Fetch with RAM always ready: 2-cycle latency.
        ld_fixed = 1'b1;
        ld_val   = 32'hDEADBEEF;
        ramready = 1'b1;
        iREN     = 1'b1;
        iaddr    = 32'h40;
        iq.push_back(32'hDEADBEEF);
        tick();
        chk("t1_ramREN", 32'(ramREN), 32'd1);
        chk("t1_ramaddr", ramaddr, 32'h40);
        chk("t1_ihit_early", 32'(ihit), 32'd0);
        tick();
        chk("t1_ihit", 32'(ihit), 32'd1);
        chk("t1_iload", iload, 32'hDEADBEEF);
        iREN     = 1'b0;
        ld_fixed = 1'b0;
        tick();

        // Simultaneous fetch and write: data first, fetch at hit+2.
        iREN   = 1'b1;
        iaddr  = 32'h140;
        dWEN   = 1'b1;
        daddr  = 32'h100;
        dstore = 32'h12345678;
        dq.push_back(32'h100 ^ KEY);
        iq.push_back(32'h140 ^ KEY);
        tick();
        chk("t2_ramWEN", 32'(ramWEN), 32'd1);
        chk("t2_ramREN", 32'(ramREN), 32'd0);
        chk("t2_ramaddr", ramaddr, 32'h100);
        chk("t2_ramstore", ramstore, 32'h12345678);
        tick();
        chk("t2_dhit", 32'(dhit), 32'd1);
        dWEN = 1'b0;
        tick();
        chk("t2_idle_en", 32'(ramREN | ramWEN), 32'd0);
        tick();
        chk("t2_iacc_ren", 32'(ramREN), 32'd1);
        chk("t2_iacc_addr", ramaddr, 32'h140);
        tick();
        chk("t2_ihit", 32'(ihit), 32'd1);
        iREN = 1'b0;
        tick();

        // Read with ramready 5 cycles late; inputs change mid-access.
        ramready = 1'b0;
        dREN     = 1'b1;
        daddr    = 32'h80;
        dq.push_back(32'h80 ^ KEY);
        tick();
        for (int i = 0; i < 6; i++) begin
            if (i == 0) begin
                dREN  = 1'b0;
                daddr = 32'hFFFF_0000;
            end
            if (i == 5) ramready = 1'b1;
            chk($sformatf("t3_ren_c%0d", i), 32'(ramREN), 32'd1);
            chk($sformatf("t3_addr_c%0d", i), ramaddr, 32'h80);
            chk($sformatf("t3_dhit_c%0d", i), 32'(dhit), 32'd0);
            tick();
        end
        chk("t3_dhit", 32'(dhit), 32'd1);
        chk("t3_dload", dload, 32'h80 ^ KEY);
        tick();
        tick();
        chk("t3_no_regrant", 32'(ramREN | ramWEN), 32'd0);

        // Timeout: ramready stuck low.
        ramready = 1'b0;
        iREN     = 1'b1;
        iaddr    = 32'h44;
        tick();
        iREN = 1'b0;
        chk("t4_err_during", 32'(err), 32'd0);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (!ramREN) break;
            cnt++;
            tick();
        end
        chk("t4_wait_cycles", 32'(cnt), 32'd8);
        chk("t4_err", 32'(err), 32'd1);
        tick();
        tick();
        tick();
        chk("t4_err_sticky", 32'(err), 32'd1);

        // Continuous data and fetch requests: grant order.
        ramready = 1'b1;
        gq.delete();
`ifdef ARB_STARVE_GUARD_EN
        exp_order = '{32'h300, 32'h300, 32'h200, 32'h300, 32'h300, 32'h200};
`else
        exp_order = '{32'h300, 32'h300, 32'h300, 32'h300, 32'h300, 32'h300};
`endif
        foreach (exp_order[i]) begin
            if (exp_order[i] == 32'h200) iq.push_back(32'h200 ^ KEY);
            else dq.push_back(32'h300 ^ KEY);
        end
        dREN  = 1'b1;
        daddr = 32'h300;
        iREN  = 1'b1;
        iaddr = 32'h200;
        done  = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (gq.size() >= 6) begin
                done = 1'b1;
                break;
            end
        end
        dREN = 1'b0;
        iREN = 1'b0;
        chk("t5_bounded", 32'(done), 32'd1);
        tick();
        tick();
        tick();
        chk("t5_grant_cnt", 32'(gq.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < gq.size()) chk($sformatf("t5_grant%0d", i), gq[i], exp_order[i]);
        end
        chk("t5_err_sticky", 32'(err), 32'd1);

        // Reset during a data write access.
        ramready = 1'b0;
        dWEN     = 1'b1;
        daddr    = 32'h500;
        dstore   = 32'h0BADF00D;
        tick();
        chk("t6_ramWEN", 32'(ramWEN), 32'd1);
        RST = 1'b1;
        tick();
        RST  = 1'b0;
        dWEN = 1'b0;
        chk("t6_ramWEN_off", 32'(ramWEN), 32'd0);
        chk("t6_ramREN_off", 32'(ramREN), 32'd0);
        chk("t6_err_clr", 32'(err), 32'd0);
        ramready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t6_no_dhit%0d", i), 32'(dhit), 32'd0);
            tick();
        end

        chk("end_iq_empty", 32'(iq.size()), 32'd0);
        chk("end_dq_empty", 32'(dq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single-port RAM between the pipeline's instruction-fetch port and its data-memory port. Each request is granted to exactly one requester, and the RAM address, data and enables are held stable until the RAM reports completion. The arbiter then returns a one-cycle hit pulse with the registered load data. It sits between the datapath's cache interface (imem/dmem ports) and the RAM.

## Interface
Parameters:
- `STARVE_LIMIT`, default 4: consecutive data grants allowed while a fetch is pending. Used only when `ARB_STARVE_GUARD_EN` is defined. Range 1–15.
- `TIMEOUT`, default 255: maximum cycles to wait for `ramready` before the access is aborted. Range 1–1023.

Ports:
- `CLK` in 1: clock; all state updates on the rising edge.
- `RST` in 1: reset, synchronous and active-high. One clock; reset is synchronous and active-high.
- `iREN` in 1: instruction read request; held until `ihit`.
- `iaddr` in 32: instruction word address.
- `iload` out 32: instruction data; valid while `ihit` is 1.
- `ihit` out 1: one-cycle fetch completion pulse.
- `dREN` in 1: data read request.
- `dWEN` in 1: data write request; takes precedence over `dREN` if both are 1.
- `daddr` in 32: data address.
- `dstore` in 32: write data.
- `dload` out 32: read data; valid while `dhit` is 1.
- `dhit` out 1: one-cycle data completion pulse.
- `ramREN` out 1: RAM read enable.
- `ramWEN` out 1: RAM write enable.
- `ramaddr` out 32: RAM address.
- `ramstore` out 32: RAM write data.
- `ramload` in 32: RAM read data; valid when `ramready` is 1.
- `ramready` in 1: RAM access complete, sampled only while the arbiter is in IACC or DACC.
- `err` out 1: sticky flag, set when a timeout abort occurs; cleared only by `RST`.

## Operation
State machine states: IDLE, IACC, DACC, IRESP, DRESP.

IDLE:
- Drives all RAM outputs to 0.
- If (`dREN` | `dWEN`) and the starvation guard is not tripped, go to DACC.
- Otherwise, if `iREN`, go to IACC.
- Otherwise, stay in IDLE.
- Data has fixed priority over instruction fetch, because a stalled MEM stage blocks the whole pipeline.

IACC:
- Drives `ramREN`=1 and `ramaddr`=`iaddr`.

DACC:
- Drives `ramaddr`=`daddr`.
- Drives `ramWEN`=`dWEN`.
- Drives `ramREN`=`dREN` & ~`dWEN`.
- Drives `ramstore`=`dstore`.
- Address, data and enable values are latched at grant and held for the whole access, even if the requester inputs change.

Completion:
- When IACC or DACC sees `ramready`=1, latch `ramload` into the response register and go to IRESP or DRESP respectively.
- IRESP asserts `ihit`=1; DRESP asserts `dhit`=1. Both then return to IDLE.
- For a write, `dload` shows the latched `ramload`, which the requester ignores.
- An access is never cancelled by its requester. If the request drops mid-access, the access still completes and the hit pulse is still emitted.

Timeout:
- A wait counter clears on entry to IACC/DACC and increments on each cycle with `ramready`=0.
- When the counter reaches `TIMEOUT`: set `err`, issue no hit, return to IDLE. The requester retries.

Reset and outputs:
- `RST` mid-access returns to IDLE immediately; RAM enables are 0 in the next cycle.
- `iload` and `dload` both come from the single response register.

## Timing
- Reset values: state=IDLE; all outputs 0, including `ihit`, `dhit`, `iload`, `dload`, all `ram*` outputs and `err`; wait and starve counters 0.
- Grant: a request seen in IDLE at cycle t drives the RAM outputs at cycle t+1.
- Latency: with `ramready` arriving k cycles after grant (k≥0, 0 meaning at cycle t+1), the hit pulse is at cycle t+2+k. The minimum request-to-hit latency is 2 cycles.
- Back-to-back: after a hit at cycle h, IDLE at h+1 re-arbitrates. A held request is granted again at h+2. Requesters must deassert or change the request on the cycle after the hit.
- Simultaneous `iREN` and data request in IDLE: data wins; the fetch waits in its held state.
- `ramready` seen outside IACC/DACC is ignored.

## Configuration
- `ARB_STARVE_GUARD_EN` defined:
  - A 4-bit counter increments on each DACC grant made while `iREN`=1.
  - The counter clears on any IACC grant, and on any IDLE cycle with `iREN`=0.
  - When the count equals `STARVE_LIMIT` and `iREN`=1, IDLE grants IACC even if a data request is present.
- Not defined: strict data priority; the counter and the `STARVE_LIMIT` logic are absent.

## Test plan
- After `RST`: all outputs are 0. `iREN`=1, `iaddr`=0x40, `ramready` held high, `ramload`=0xDEADBEEF. Required: `ramREN`/`ramaddr`=0x40 driven one cycle after the request; `ihit`=1 with `iload`=0xDEADBEEF 2 cycles after the request.
- Same-cycle `iREN`=1 and `dWEN`=1 (`daddr`=0x100, `dstore`=0x12345678), `ramready` high. Required: `ramWEN`=1 with `ramstore`=0x12345678 first; `dhit` pulses; the fetch is granted at the second cycle after the hit and `ihit` follows.
- `dREN` with `ramready` delayed 5 cycles after grant. Required: RAM outputs stable for all 6 access cycles; `dhit` 7 cycles after the request.
- `ramready` stuck at 0, `TIMEOUT`=8. Required: after 8 wait cycles, return to IDLE; `err`=1 and stays 1; no hit is issued.
- With `ARB_STARVE_GUARD_EN`, `STARVE_LIMIT`=2, continuous `dREN` and `iREN`. Required grant order: D, D, I, D, D, I.
- `RST` asserted during DACC. Required: `ramREN`/`ramWEN`=0 in the next cycle, no `dhit`, `err` cleared.
